// File: rtl/tdc_meas_ctrl_if.sv
// Request/result handshake between the TDC measurement sequencer and its consumer.
//   start        consumer -> sequencer   measurement request
//   result_ready consumer -> sequencer   result accepted when high with result_valid
//   busy         sequencer -> consumer   sequencer not idle
//   result       sequencer -> consumer   mean stage count (CW bits)
//   result_valid sequencer -> consumer   result/flags valid, held until accepted
//   ovf          sequencer -> consumer   sticky: a sample saturated the chain
//   bubble_err   sequencer -> consumer   sticky: a sample was not thermometer-coded
interface tdc_meas_ctrl_if #(
  parameter int CW = 5
) ();
  logic          start;
  logic          result_ready;
  logic          busy;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          ovf;
  logic          bubble_err;

  modport master (
    output start, result_ready,
    input  busy, result, result_valid, ovf, bubble_err
  );

  modport slave (
    input  start, result_ready,
    output busy, result, result_valid, ovf, bubble_err
  );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the inverter delay-line sensor. Each request launches
// 2**LOG2_SAMPLES edges into the chain, converts each captured thermometer tap vector
// into a stage count, accumulates the counts and presents the truncated mean.
//   clk, rst_n  clock / asynchronous active-low reset
//   launch      registered edge into the delay-line input
//   taps        delay-line tap vector, taps[0] nearest the launch point
//   mif         request/result handshake (slave side)
module tdc_meas_ctrl #(
  parameter int N_DELAY       = 16,
  parameter int LOG2_SAMPLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               launch,
  input  logic [N_DELAY-1:0] taps,
  tdc_meas_ctrl_if.slave     mif
);
  localparam int CW  = $clog2(N_DELAY + 1);
  localparam int AW  = CW + LOG2_SAMPLES;
  localparam int SW  = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  LAST_SMP = SW'((1 << LOG2_SAMPLES) - 1);
  localparam logic [STW-1:0] LAST_SET = STW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_CAPTURE, S_RECOVER, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [N_DELAY-1:0] tap_q, tap_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [SW-1:0]      smp_q, smp_d;
  logic [STW-1:0]     set_q, set_d;
  logic               ovf_q, ovf_d;
  logic               bub_q, bub_d;
  logic               launch_q, launch_d;

  logic [CW-1:0]      cnt_c;
  logic               bub_c;
  logic               run_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (mif.start) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RECOVER;
      S_RECOVER: if (set_q == LAST_SET)
                   state_d = (smp_q == LAST_SMP) ? S_DONE : S_LAUNCH;
      S_DONE:    if (mif.result_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs. launch is decoded from the next state and registered so the
  // chain input never sees a combinational glitch.
  always_comb begin
    launch_d         = (state_d == S_LAUNCH) || (state_d == S_CAPTURE);
    launch           = launch_q;
    mif.busy         = (state_q != S_IDLE);
    mif.result_valid = (state_q == S_DONE);
    mif.result       = acc_q[AW-1:LOG2_SAMPLES];
    mif.ovf          = ovf_q;
    mif.bubble_err   = bub_q;
  end

  // Leading-ones count from tap 0; any 1 after the first 0 is a bubble.
  always_comb begin
    cnt_c = '0;
    bub_c = 1'b0;
    run_c = 1'b1;
    for (int i = 0; i < N_DELAY; i++) begin
      if (tap_q[i]) begin
        if (run_c) cnt_c = cnt_c + CW'(1);
        else       bub_c = 1'b1;
      end else begin
        run_c = 1'b0;
      end
    end
  end

  // Datapath next-state
  always_comb begin
    tap_d = tap_q;
    acc_d = acc_q;
    smp_d = smp_q;
    set_d = set_q;
    ovf_d = ovf_q;
    bub_d = bub_q;
    case (state_q)
      S_IDLE: if (mif.start) begin
        acc_d = '0;
        smp_d = '0;
        ovf_d = 1'b0;
        bub_d = 1'b0;
      end
      // taps are asynchronous to the launch path; this is their only sample point.
      S_LAUNCH: tap_d = taps;
      S_CAPTURE: begin
        acc_d = acc_q + AW'(cnt_c);
        ovf_d = ovf_q | (&tap_q);
        bub_d = bub_q | bub_c;
        set_d = '0;
      end
      S_RECOVER: begin
        set_d = set_q + STW'(1);
        if (set_q == LAST_SET && smp_q != LAST_SMP) smp_d = smp_q + SW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q    <= '0;
      acc_q    <= '0;
      smp_q    <= '0;
      set_q    <= '0;
      ovf_q    <= 1'b0;
      bub_q    <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      tap_q    <= tap_d;
      acc_q    <= acc_d;
      smp_q    <= smp_d;
      set_q    <= set_d;
      ovf_q    <= ovf_d;
      bub_q    <= bub_d;
      launch_q <= launch_d;
    end
  end
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
module tb_tdc_meas_ctrl;
  logic        clk;
  logic        rst_n;
  logic        launch;
  logic [15:0] taps;
  int          n_chk;
  int          n_fail;

  tdc_meas_ctrl_if #(.CW(5)) mif ();

  tdc_meas_ctrl #(.N_DELAY(16), .LOG2_SAMPLES(2), .SETTLE_CYCLES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .launch (launch),
    .taps   (taps),
    .mif    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [3:0][15:0] tv;
    logic [4:0]      res;
    logic            ovf;
    logic            bub;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full measurement: start pulse, per-sample taps applied during LAUNCH,
  // launch/busy/valid traced per cycle, result checked, then handshake.
  task automatic run_meas(input vec_t v);
    logic [15:0] lpat, bpat, vpat;
    lpat = '0; bpat = '0; vpat = '0;
    @(negedge clk);
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) taps = v.tv[k/4];
      lpat[k] = launch;
      bpat[k] = mif.busy;
      vpat[k] = mif.result_valid;
      @(negedge clk);
    end
    chk({v.name, " launch pattern"}, 32'(lpat), 32'h3333);
    chk({v.name, " busy during run"}, 32'(bpat), 32'hFFFF);
    chk({v.name, " valid early"}, 32'(vpat), 32'h0);
    chk({v.name, " valid at 16"}, 32'(mif.result_valid), 32'd1);
    chk({v.name, " result"}, 32'(mif.result), 32'(v.res));
    chk({v.name, " ovf"}, 32'(mif.ovf), 32'(v.ovf));
    chk({v.name, " bubble"}, 32'(mif.bubble_err), 32'(v.bub));
    mif.result_ready = 1'b1;
    @(negedge clk);
    mif.result_ready = 1'b0;
    chk({v.name, " idle after ack"}, {mif.busy, mif.result_valid}, 32'd0);
    chk({v.name, " result held"}, 32'(mif.result), 32'(v.res));
  endtask

  initial begin
    int k;
    int stable;
    logic seen_busy;
    n_chk = 0; n_fail = 0;
    vecs[0] = '{"flat_ff",    {16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF}, 5'd8,  1'b0, 1'b0};
    vecs[1] = '{"ramp",       {16'h03FF, 16'h00FF, 16'h003F, 16'h000F}, 5'd7,  1'b0, 1'b0};
    vecs[2] = '{"all_ones",   {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 5'd16, 1'b1, 1'b0};
    vecs[3] = '{"single",     {16'h0001, 16'h0001, 16'h0001, 16'h0001}, 5'd1,  1'b0, 1'b0};
    vecs[4] = '{"bubble",     {16'h00F7, 16'h00F7, 16'h00F7, 16'h00F7}, 5'd3,  1'b0, 1'b1};
    vecs[5] = '{"zeros",      {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 5'd0,  1'b0, 1'b0};
    vecs[6] = '{"one_ovf",    {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 5'd4,  1'b1, 1'b0};
    vecs[7] = '{"truncate",   {16'h0000, 16'h0001, 16'h0003, 16'h0007}, 5'd1,  1'b0, 1'b0};

    rst_n = 1'b0; mif.start = 1'b0; mif.result_ready = 1'b0; taps = '0;
    #12;
    chk("reset outputs", {launch, mif.busy, mif.result_valid, mif.ovf, mif.bubble_err},
        32'd0);
    chk("reset result", 32'(mif.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_meas(vecs[i]);

    // start ignored while busy and in DONE; result held while ready is low
    taps = 16'h003F;
    @(negedge clk);
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    k = 0;
    while (!mif.result_valid && k < 40) begin
      mif.start = (k == 5 || k == 9);
      @(negedge clk);
      k++;
    end
    mif.start = 1'b0;
    chk("reissue latency", 32'(k), 32'd16);
    mif.start = 1'b1;
    stable = 0;
    for (int c = 0; c < 10; c++) begin
      if (mif.result_valid && mif.result == 5'd6) stable++;
      @(negedge clk);
    end
    chk("held 10 cycles", 32'(stable), 32'd10);
    mif.result_ready = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    mif.result_ready = 1'b0;
    chk("idle after ready", {mif.busy, mif.result_valid}, 32'd0);
    seen_busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      seen_busy |= mif.busy;
      @(negedge clk);
    end
    chk("start not queued", 32'(seen_busy), 32'd0);

    // reset during RECOVER of sample 2
    taps = 16'hFFFF;
    @(negedge clk);
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("pre-abort ovf", 32'(mif.ovf), 32'd1);
    chk("pre-abort launch low", 32'(launch), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort outputs", {launch, mif.busy, mif.result_valid, mif.ovf, mif.bubble_err},
        32'd0);
    chk("abort result", 32'(mif.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_meas('{"post_reset", {16'h0003, 16'h0003, 16'h0003, 16'h0003}, 5'd2, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
